mdio_master: RTL
================

// Module: mdio_master
// PURPOSE
//  Clause-22 MDIO/SMI management controller for the Ethernet PHY.
//  Turns single read/write commands into serial MDC/MDIO frames that configure the PHY and read its status.
//  Sits between the control logic and the phy1_mii_clk/phy1_mii_data pins.
//  Top level builds the inout pad: phy1_mii_data = mii_data_oe ? mii_data_o : 1'bz.
// PARAMETERS
//  CLK_DIV   25  clock cycles per MDC half-period (125 MHz -> 2.5 MHz MDC); legal >= 2
//  PREAMBLE  1   1: send 32-bit all-ones preamble; 0: suppress preamble (frame = 32 bits)
// PORTS
//  clock         in   1   system clock; every register is on its rising edge
//  reset         in   1   synchronous, active-high reset
//  cmd_valid     in   1   command request
//  cmd_ready     out  1   high in IDLE only; command accepted when cmd_valid & cmd_ready
//  cmd_write     in   1   1 = write, 0 = read
//  cmd_phy_addr  in   5   PHYAD
//  cmd_reg_addr  in   5   REGAD
//  cmd_wdata     in   16  write data (ignored for reads)
//  rsp_valid     out  1   1-cycle pulse at frame end (reads and writes)
//  rsp_rdata     out  16  read data; held until the next read completes
//  rsp_err       out  1   read turnaround bit 2 sampled as 1 (no PHY); valid with rsp_valid
//  mii_clk       out  1   MDC
//  mii_data_o    out  1   MDIO output value
//  mii_data_oe   out  1   MDIO output enable
//  mii_data_i    in   1   MDIO input (pad value)
// BEHAVIOUR
//  Reset: cmd_ready=0 during reset and 1 the cycle after. rsp_valid=0, rsp_rdata=0, rsp_err=0,
//   mii_clk=0, mii_data_o=1, mii_data_oe=0. Reset mid-frame aborts immediately with no rsp_valid.
//  Bit period = 2*CLK_DIV cycles.
//   mii_clk is low for the first CLK_DIV cycles and high for the last CLK_DIV.
//   mii_data_o changes only at the start of a bit period (the MDC falling edge).
//  Frame: [PRE 32x'1'] ST=01, OP (write 01 / read 10), PHYAD[4:0] MSB first, REGAD[4:0] MSB first,
//   TA, DATA[15:0] MSB first. Total 64 bits (32 with PREAMBLE=0).
//  Write: TA=10 driven; DATA driven from cmd_wdata; oe=1 for the whole frame.
//  Read: oe=1 through REGAD; oe=0 from the first TA bit to frame end.
//   mii_data_i is sampled in the cycle mii_clk goes 0->1.
//   TA bit 2 sample -> rsp_err; the 16 DATA samples shift into rsp_rdata MSB first.
//   rsp_rdata is updated only when rsp_valid pulses.
//  FSM: IDLE -> PRE (skipped if PREAMBLE=0) -> HDR (14 bits) -> TA (2) -> DATA (16) -> GAP (1 bit period) -> IDLE.
//   GAP: mii_clk=0, oe=0, cmd_ready=0.
//  Commands are latched on acceptance; input changes during a frame have no effect.
//  cmd_valid while cmd_ready=0 is ignored; it is not queued.
//  Timing, accept at cycle T, N = frame bits:
//   first bit period starts at T+1;
//   rsp_valid pulses at T+1+N*2*CLK_DIV;
//   cmd_ready is back high at T+1+(N+1)*2*CLK_DIV.
//   Back-to-back commands are therefore spaced (N+1)*2*CLK_DIV+1 cycles apart.
//  Counters: divider is $clog2(2*CLK_DIV) bits and wraps at 2*CLK_DIV-1; bit counter is 6 bits.
//   No other arithmetic.
//  IDLE: mii_clk=0, oe=0, mii_data_o=1.
// TESTING
//  1 CLK_DIV=2, PREAMBLE=1, write phy=1 reg=0 data=16'h1140 ->
//    MDIO sampled at MDC rise = 32x1, 01 01 00001 00000 10 0001000101000000;
//    oe=1 throughout; rsp_valid at T+257; cmd_ready at T+261.
//  2 Read phy=1 reg=2; PHY model drives TA2=0 then 16'h0141 from MDC falling edges ->
//    rsp_rdata=16'h0141, rsp_err=0; oe=0 from bit 46 (first TA bit) to frame end.
//  3 Read with mii_data_i held 1 (no PHY) -> rsp_rdata=16'hFFFF, rsp_err=1, single rsp_valid pulse.
//  4 PREAMBLE=0, CLK_DIV=2, write -> 32-bit frame starting with 01; rsp_valid at T+129.
//  5 cmd_valid held high during a frame with different addr/data ->
//    serialized frame matches the first command; second command is accepted only when cmd_ready returns.
//  6 reset asserted at bit 40 of a read ->
//    next cycle mii_clk=0, oe=0, no rsp_valid, rsp_rdata=0;
//    a fresh write after reset completes normally.

Source files
------------

// File: rtl/mdio_master.sv
// mdio_master: Clause-22 MDIO/SMI management master.
// Turns a single read/write command into one serial MDC/MDIO frame and
// reports completion with a one-cycle response pulse.
//
// Ports
//   clock, reset                  system clock, synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake (ready only in IDLE)
//   cmd_write                     1 = write, 0 = read
//   cmd_phy_addr, cmd_reg_addr    PHYAD / REGAD
//   cmd_wdata                     write data
//   rsp_valid                     one-cycle pulse at frame end
//   rsp_rdata, rsp_err            read data / no-PHY flag (rdata held between reads)
//   mii_clk                       MDC
//   mii_data_o, mii_data_oe       MDIO output value and enable (pad built above)
//   mii_data_i                    MDIO pad value
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// PRE   | 32 preamble ones
// HDR   | ST, OP, PHYAD, REGAD (14 bits)
// TA    | turnaround (driven 10 on writes, released on reads)
// DATA  | 16 data bits, MSB first
// GAP   | one idle bit period before the next command
module mdio_master #(
  parameter int CLK_DIV  = 25,
  parameter bit PREAMBLE = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phy_addr,
  input  logic [4:0]  cmd_reg_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mii_clk,
  output logic        mii_data_o,
  output logic        mii_data_oe,
  input  logic        mii_data_i
);

  localparam int DIV_W = $clog2(2 * CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV);

  typedef enum logic [2:0] {
    ST_IDLE, ST_PRE, ST_HDR, ST_TA, ST_DATA, ST_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q;
  logic [5:0]       bit_q;
  logic [31:0]      frame_q;
  logic             write_q;
  logic [15:0]      rd_sh_q;
  logic             ta_err_q;
  logic             accept;
  logic             bit_end;
  logic             mdc_rise;
  logic             mdc_high;
  logic             last_bit;

  assign accept   = cmd_valid && cmd_ready;
  assign bit_end  = (div_q == DIV_LAST);
  assign mdc_rise = (div_q == DIV_HALF);
  assign mdc_high = (div_q >= DIV_HALF);

  always_comb begin
    state_d     = state_q;
    last_bit    = 1'b0;
    cmd_ready   = 1'b0;
    mii_clk     = 1'b0;
    mii_data_o  = 1'b1;
    mii_data_oe = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // gated by reset so ready stays low for the whole reset window
        cmd_ready = !reset;
        if (cmd_valid && !reset) state_d = PREAMBLE ? ST_PRE : ST_HDR;
      end
      ST_PRE: begin
        last_bit    = (bit_q == 6'd31);
        mii_clk     = mdc_high;
        mii_data_oe = 1'b1;
        if (bit_end && last_bit) state_d = ST_HDR;
      end
      ST_HDR: begin
        last_bit    = (bit_q == 6'd13);
        mii_clk     = mdc_high;
        mii_data_o  = frame_q[31];
        mii_data_oe = 1'b1;
        if (bit_end && last_bit) state_d = ST_TA;
      end
      ST_TA: begin
        last_bit    = (bit_q == 6'd1);
        mii_clk     = mdc_high;
        mii_data_o  = frame_q[31];
        mii_data_oe = write_q;
        if (bit_end && last_bit) state_d = ST_DATA;
      end
      ST_DATA: begin
        last_bit    = (bit_q == 6'd15);
        mii_clk     = mdc_high;
        mii_data_o  = frame_q[31];
        mii_data_oe = write_q;
        if (bit_end && last_bit) state_d = ST_GAP;
      end
      ST_GAP: begin
        if (bit_end) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      frame_q   <= '1;
      write_q   <= 1'b0;
      rd_sh_q   <= '0;
      ta_err_q  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rsp_valid <= 1'b0;
      if (accept) begin
        div_q   <= '0;
        bit_q   <= '0;
        write_q <= cmd_write;
        // read frames carry ones in TA/DATA; those bits are never driven
        frame_q <= {2'b01, (cmd_write ? 2'b01 : 2'b10), cmd_phy_addr, cmd_reg_addr,
                    (cmd_write ? 2'b10 : 2'b11), (cmd_write ? cmd_wdata : 16'hFFFF)};
      end else if (state_q != ST_IDLE) begin
        div_q <= bit_end ? '0 : div_q + DIV_W'(1);
        if (bit_end) begin
          bit_q <= (state_d != state_q) ? 6'd0 : bit_q + 6'd1;
          if (state_q != ST_PRE) frame_q <= {frame_q[30:0], 1'b1};
        end
        if (mdc_rise && !write_q) begin
          if (state_q == ST_TA && bit_q == 6'd1) ta_err_q <= mii_data_i;
          if (state_q == ST_DATA) rd_sh_q <= {rd_sh_q[14:0], mii_data_i};
        end
        if (state_q == ST_DATA && state_d == ST_GAP) begin
          rsp_valid <= 1'b1;
          rsp_err   <= !write_q && ta_err_q;
          if (!write_q) rsp_rdata <= rd_sh_q;
        end
      end
    end
  end

endmodule
